// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO read/write controllers: Gray-code
// helpers, pointer width derivation and output-buffer occupancy codes.
package async_fifo_pkg;

  localparam int GRAY_MAX_W = 32;

  localparam logic [1:0] BUF_EMPTY = 2'd0;
  localparam logic [1:0] BUF_ONE   = 2'd1;
  localparam logic [1:0] BUF_TWO   = 2'd2;

  // One extra pointer bit distinguishes full from empty.
  function automatic int ptr_width(input int depth);
    return depth + 1;
  endfunction

  // Width-generic: callers zero-extend to GRAY_MAX_W and truncate the result.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing clock domains.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage1 <= '0;
      q_o    <= '0;
    end else begin
      stage1 <= d_i;
      q_o    <= stage1;
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO: pointer sync, empty/level, and
// RAM read sequencing into a 2-entry first-word-fall-through output buffer.
module fifo_rd_ctrl
  import async_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 32,
  localparam int PW = ptr_width(FIFO_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [PW-1:0]         wr_ptr_gray_i,
  output logic [PW-1:0]         rd_ptr_gray_o,
  output logic                  ram_rd_en_o,
  output logic [FIFO_DEPTH-1:0] ram_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_rd_data_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic                  empty_o,
  output logic [PW-1:0]         rd_level_o
);

  logic [PW-1:0]         wsync2;
  logic [PW-1:0]         wr_bin_s;
  logic [PW-1:0]         rd_bin;
  logic [PW-1:0]         rd_bin_nxt;
  logic [1:0]            buf_cnt;
  logic [1:0]            buf_cnt_nxt;
  logic [2:0]            occ;
  logic                  inflight;
  logic                  pop;
  logic                  issue;
  logic                  cap;
  logic                  cap_head;
  logic [DATA_WIDTH-1:0] skid;

  sync_2ff #(.WIDTH(PW)) u_wsync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (wr_ptr_gray_i),
    .q_o   (wsync2)
  );

  assign wr_bin_s   = PW'(gray2bin(GRAY_MAX_W'(wsync2)));
  assign rd_bin_nxt = rd_bin + PW'(1);

  // Full PW-bit Gray compare keeps empty detection correct across wrap.
  assign empty_o = (rd_ptr_gray_o == wsync2);

  assign pop = rd_valid_o & rd_ready_i;
  assign cap = inflight;
  // Words held or owed to the buffer after this cycle's pop.
  assign occ   = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue = !empty_o && (occ < {1'b0, BUF_TWO});

  assign ram_rd_en_o   = issue;
  assign ram_rd_addr_o = rd_bin[FIFO_DEPTH-1:0];

  assign cap_head = cap && ((buf_cnt == BUF_EMPTY) || ((buf_cnt == BUF_ONE) && pop));

  always_comb begin
    buf_cnt_nxt = buf_cnt;
    case ({pop, cap})
      2'b10:   buf_cnt_nxt = buf_cnt - 2'd1;
      2'b01:   buf_cnt_nxt = buf_cnt + 2'd1;
      default: buf_cnt_nxt = buf_cnt;
    endcase
  end

  // Pointer / issue stage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_bin        <= '0;
      rd_ptr_gray_o <= '0;
      inflight      <= 1'b0;
      rd_level_o    <= '0;
    end else begin
      if (issue) begin
        rd_bin        <= rd_bin_nxt;
        rd_ptr_gray_o <= PW'(bin2gray(GRAY_MAX_W'(rd_bin_nxt)));
      end
      inflight   <= issue;
      rd_level_o <= wr_bin_s - rd_bin;
    end
  end

  // Capture / output buffer stage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_cnt    <= BUF_EMPTY;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      skid       <= '0;
    end else begin
      buf_cnt    <= buf_cnt_nxt;
      rd_valid_o <= (buf_cnt_nxt != BUF_EMPTY);
      if (cap_head) begin
        rd_data_o <= ram_rd_data_i;
      end else if (pop) begin
        rd_data_o <= skid;
      end
      if (cap && !cap_head) begin
        skid <= ram_rd_data_i;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl at FIFO_DEPTH=3 with a 1-cycle RAM model.
module tb_fifo_rd_ctrl;

  localparam int FD = 3;
  localparam int DW = 32;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] wr_ptr_gray;
  logic [PW-1:0] rd_ptr_gray;
  logic          ram_rd_en;
  logic [FD-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          empty;
  logic [PW-1:0] rd_level;

  logic [DW-1:0] mem [8];
  int n_checks = 0;
  int n_fail   = 0;
  int en_seen;
  int vld_seen;
  int na;
  int nd;
  logic [DW-1:0] addr_log [4];
  logic [DW-1:0] data_log [4];

  fifo_rd_ctrl #(.FIFO_DEPTH(FD), .DATA_WIDTH(DW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .wr_ptr_gray_i (wr_ptr_gray),
    .rd_ptr_gray_o (rd_ptr_gray),
    .ram_rd_en_o   (ram_rd_en),
    .ram_rd_addr_o (ram_rd_addr),
    .ram_rd_data_i (ram_rd_data),
    .rd_data_o     (rd_data),
    .rd_valid_o    (rd_valid),
    .rd_ready_i    (rd_ready),
    .empty_o       (empty),
    .rd_level_o    (rd_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] gray4(input int v);
    logic [3:0] b;
    b = 4'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_gray"},  32'(rd_ptr_gray), 32'h0);
    check_val({tag, "_en"},    32'(ram_rd_en),   32'h0);
    check_val({tag, "_valid"}, 32'(rd_valid),    32'h0);
    check_val({tag, "_data"},  rd_data,          32'h0);
    check_val({tag, "_empty"}, 32'(empty),       32'h1);
    check_val({tag, "_level"}, 32'(rd_level),    32'h0);
  endtask

  initial begin
    rst         = 1'b1;
    wr_ptr_gray = '0;
    rd_ready    = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 32'h100 + 32'(i);
    step();
    step();
    check_reset_outputs("rst");
    rst = 1'b0;

    // Idle after reset
    en_seen = 0;
    repeat (6) begin
      step();
      if (ram_rd_en) en_seen++;
    end
    check_val("idle_en_cnt", 32'(en_seen), 32'd0);
    check_val("idle_empty", 32'(empty), 32'h1);
    check_val("idle_valid", 32'(rd_valid), 32'h0);
    check_val("idle_level", 32'(rd_level), 32'h0);

    // Single word, latency
    mem[0] = 32'hA5;
    wr_ptr_gray = gray4(1);
    step();
    check_val("one_e1_en", 32'(ram_rd_en), 32'h0);
    step();
    check_val("one_e2_en", 32'(ram_rd_en), 32'h1);
    check_val("one_e2_addr", 32'(ram_rd_addr), 32'h0);
    step();
    check_val("one_e3_en", 32'(ram_rd_en), 32'h0);
    check_val("one_e3_valid", 32'(rd_valid), 32'h0);
    check_val("one_e3_gray", 32'(rd_ptr_gray), 32'h1);
    check_val("one_e3_level", 32'(rd_level), 32'h1);
    step();
    check_val("one_e4_valid", 32'(rd_valid), 32'h1);
    check_val("one_e4_data", rd_data, 32'hA5);
    check_val("one_e4_empty", 32'(empty), 32'h1);
    check_val("one_e4_level", 32'(rd_level), 32'h0);
    rd_ready = 1'b1;
    step();
    check_val("one_pop_valid", 32'(rd_valid), 32'h0);
    rd_ready = 1'b0;

    // Eight words, consumer stalled
    do_reset();
    mem[0] = 32'h100;
    wr_ptr_gray = gray4(8);
    en_seen = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (ram_rd_en) en_seen++;
      if (c == 3) check_val("stall_level_e3", 32'(rd_level), 32'd8);
      if (c == 4) check_val("stall_level_e4", 32'(rd_level), 32'd7);
      if (c >= 5) check_val("stall_hold_data", rd_data, 32'h100);
    end
    check_val("stall_en_cnt", 32'(en_seen), 32'd2);
    check_val("stall_valid", 32'(rd_valid), 32'h1);
    check_val("stall_empty", 32'(empty), 32'h0);
    check_val("stall_level", 32'(rd_level), 32'd6);

    // Drain at full throughput
    rd_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_val("drain_valid", 32'(rd_valid), 32'h1);
      check_val("drain_data", rd_data, 32'h100 + 32'(k));
      step();
    end
    check_val("drain_end_valid", 32'(rd_valid), 32'h0);
    check_val("drain_end_empty", 32'(empty), 32'h1);
    check_val("drain_end_gray", 32'(rd_ptr_gray), 32'b1100);
    step();
    check_val("drain_end_level", 32'(rd_level), 32'h0);

    // Advance both pointers to 14, then wrap through 16
    wr_ptr_gray = gray4(14);
    repeat (16) step();
    check_val("pre_wrap_gray", 32'(rd_ptr_gray), 32'(gray4(14)));
    check_val("pre_wrap_empty", 32'(empty), 32'h1);
    mem[6] = 32'hC6;
    mem[7] = 32'hC7;
    mem[0] = 32'hC0;
    mem[1] = 32'hC1;
    wr_ptr_gray = gray4(2);
    na = 0;
    nd = 0;
    repeat (15) begin
      if (ram_rd_en) begin
        if (na < 4) addr_log[na] = 32'(ram_rd_addr);
        na++;
      end
      if (rd_valid && rd_ready) begin
        if (nd < 4) data_log[nd] = rd_data;
        nd++;
      end
      step();
    end
    check_val("wrap_n_reads", 32'(na), 32'd4);
    check_val("wrap_n_words", 32'(nd), 32'd4);
    check_val("wrap_addr0", addr_log[0], 32'd6);
    check_val("wrap_addr1", addr_log[1], 32'd7);
    check_val("wrap_addr2", addr_log[2], 32'd0);
    check_val("wrap_addr3", addr_log[3], 32'd1);
    check_val("wrap_data0", data_log[0], 32'hC6);
    check_val("wrap_data1", data_log[1], 32'hC7);
    check_val("wrap_data2", data_log[2], 32'hC0);
    check_val("wrap_data3", data_log[3], 32'hC1);
    check_val("wrap_gray", 32'(rd_ptr_gray), 32'(gray4(2)));
    check_val("wrap_empty", 32'(empty), 32'h1);

    // Asynchronous reset mid-stream
    rd_ready = 1'b0;
    mem[2] = 32'h102;
    wr_ptr_gray = gray4(7);
    repeat (4) step();
    check_val("mid_pre_valid", 32'(rd_valid), 32'h1);
    check_val("mid_pre_data", rd_data, 32'h102);
    @(posedge clk);
    #2;
    rst = 1'b1;
    wr_ptr_gray = '0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    en_seen  = 0;
    vld_seen = 0;
    repeat (8) begin
      step();
      if (ram_rd_en) en_seen++;
      if (rd_valid) vld_seen++;
    end
    check_val("post_rst_en_cnt", 32'(en_seen), 32'd0);
    check_val("post_rst_valid_cnt", 32'(vld_seen), 32'd0);
    check_val("post_rst_empty", 32'(empty), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
